// File: rtl/sync_edge_detect.sv
// Multi-channel synchronising edge detector with sticky pending flags,
// a registered interrupt and a saturating event counter.
//
// Ports:
//   clk      - single clock, rising edge
//   rst_n    - asynchronous active-low reset
//   in       - WIDTH asynchronous level inputs
//   mode     - 00 rising, 01 falling, 10 any change, 11 disabled
//   clr      - synchronous clear of pending and evt_cnt
//   ack      - per-channel clear of pending
//   pedge    - registered one-cycle detect pulse per channel
//   pending  - sticky per-channel event flag
//   irq      - registered OR of pending
//   evt_cnt  - saturating count of cycles with any pedge bit set
module sync_edge_detect #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    input  logic [1:0]       mode,
    input  logic             clr,
    input  logic [WIDTH-1:0] ack,
    output logic [WIDTH-1:0] pedge,
    output logic [WIDTH-1:0] pending,
    output logic             irq,
    output logic [CNT_W-1:0] evt_cnt
);

    localparam logic [2:0] WARM_N  = 3'(SYNC_STAGES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] det;
    logic [2:0]       wcnt;
    logic             warm_done;

    assign s         = sync_q[SYNC_STAGES-1];
    assign warm_done = (wcnt == WARM_N);

    // Synchroniser chain and the one-cycle delayed copy of its output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
            p <= '0;
        end else begin
            sync_q[0] <= in;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
            p <= s;
        end
    end

    // Warm-up: hold off detection until the chain and p hold
    // real samples, so a level present at release is not an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt <= '0;
        end else if (!warm_done) begin
            wcnt <= wcnt + 3'd1;
        end
    end

    always_comb begin
        det = '0;
        unique case (mode)
            2'b00:   det = s & ~p;
            2'b01:   det = ~s & p;
            2'b10:   det = s ^ p;
            default: det = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pedge <= '0;
        end else if (warm_done) begin
            pedge <= det;
        end else begin
            pedge <= '0;
        end
    end

    // A new pulse wins over a same-cycle ack; clr wins over both.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else if (clr) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~ack) | pedge;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_cnt <= '0;
        end else if (clr) begin
            evt_cnt <= '0;
        end else if ((|pedge) && (evt_cnt != CNT_MAX)) begin
            evt_cnt <= evt_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq <= 1'b0;
        end else begin
            irq <= |pending;
        end
    end

endmodule

// File: tb/tb_sync_edge_detect.sv
// Directed bench for sync_edge_detect: default instance plus a
// CNT_W=2 instance sharing the same stimulus for saturation checks.
module tb_sync_edge_detect;

    logic       clk;
    logic       rst_n;
    logic [7:0] din;
    logic [1:0] mode;
    logic       clr;
    logic [7:0] ack;

    logic [7:0] pedge0, pend0, cnt0;
    logic       irq0;
    logic [7:0] pedge1, pend1;
    logic [1:0] cnt1;
    logic       irq1;

    int total = 0;
    int bad   = 0;
    logic [7:0] seen;
    logic [1:0] sat_exp [5];

    sync_edge_detect #(.WIDTH(8), .SYNC_STAGES(2), .CNT_W(8)) u0 (
        .clk(clk), .rst_n(rst_n), .in(din), .mode(mode),
        .clr(clr), .ack(ack), .pedge(pedge0), .pending(pend0),
        .irq(irq0), .evt_cnt(cnt0)
    );

    sync_edge_detect #(.WIDTH(8), .SYNC_STAGES(2), .CNT_W(2)) u1 (
        .clk(clk), .rst_n(rst_n), .in(din), .mode(mode),
        .clr(clr), .ack(ack), .pedge(pedge1), .pending(pend1),
        .irq(irq1), .evt_cnt(cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Step n cycles, collecting every pedge bit seen on u0.
    task automatic run(input int n);
        seen = '0;
        for (int i = 0; i < n; i++) begin
            step();
            seen |= pedge0;
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_pedge"}, 32'(pedge0), 32'h0);
        chk({tag, "_pend"}, 32'(pend0), 32'h0);
        chk({tag, "_irq"}, 32'(irq0), 32'h0);
        chk({tag, "_cnt"}, 32'(cnt0), 32'h0);
        chk({tag, "_cnt1"}, 32'(cnt1), 32'h0);
    endtask

    initial begin
        sat_exp[0] = 2'd1;
        sat_exp[1] = 2'd2;
        sat_exp[2] = 2'd3;
        sat_exp[3] = 2'd3;
        sat_exp[4] = 2'd3;

        // Reset with a static high input held through release.
        rst_n = 1'b0;
        din   = 8'hFF;
        mode  = 2'b00;
        clr   = 1'b0;
        ack   = 8'h00;
        step();
        step();
        chk_zero("reset");
        rst_n = 1'b1;
        run(6);
        chk("static_hi_pedge", 32'(seen), 32'h0);
        chk("static_hi_pend", 32'(pend0), 32'h0);
        chk("static_hi_cnt", 32'(cnt0), 32'h0);

        // Falling edges are ignored in rising mode.
        din = 8'h00;
        run(4);
        chk("fall_in_rise", 32'(seen), 32'h0);

        // Rising 0x00 -> 0x05, latency and single-cycle pulse.
        din = 8'h05;
        step();
        step();
        chk("rise_early", 32'(pedge0), 32'h0);
        step();
        chk("rise_pedge", 32'(pedge0), 32'h05);
        step();
        chk("rise_once", 32'(pedge0), 32'h0);
        chk("rise_pend", 32'(pend0), 32'h05);
        chk("rise_cnt", 32'(cnt0), 32'd1);
        chk("rise_irq_lag", 32'(irq0), 32'h0);
        step();
        chk("rise_irq", 32'(irq0), 32'h1);

        // Acknowledge both channels.
        ack = 8'h05;
        step();
        ack = 8'h00;
        chk("ack_pend", 32'(pend0), 32'h0);
        step();
        chk("ack_irq", 32'(irq0), 32'h0);

        // Falling mode.
        mode = 2'b01;
        din  = 8'h04;
        run(3);
        chk("fall_pedge", 32'(pedge0), 32'h01);
        step();
        chk("fall_pend", 32'(pend0), 32'h01);
        chk("fall_cnt", 32'(cnt0), 32'd2);

        // Any-change mode.
        mode = 2'b10;
        din  = 8'h84;
        run(3);
        chk("any_pedge", 32'(pedge0), 32'h80);
        step();
        chk("any_pend", 32'(pend0), 32'h81);
        chk("any_cnt", 32'(cnt0), 32'd3);

        // Disabled: no detection for any change.
        mode = 2'b11;
        din  = 8'h7B;
        run(5);
        chk("dis_pedge", 32'(seen), 32'h0);
        chk("dis_cnt", 32'(cnt0), 32'd3);

        // Re-enabling does not report edges that already happened.
        mode = 2'b00;
        run(4);
        chk("no_retro", 32'(seen), 32'h0);

        ack = 8'hFF;
        step();
        ack = 8'h00;
        chk("ack_all", 32'(pend0), 32'h0);

        // New pedge[0] with ack in the same cycle keeps pending set.
        din = 8'h7A;
        run(3);
        din = 8'h7B;
        run(3);
        chk("bit0_pedge", 32'(pedge0), 32'h01);
        step();
        chk("bit0_pend", 32'(pend0), 32'h01);
        din = 8'h7A;
        run(3);
        din = 8'h7B;
        run(3);
        chk("bit0_pedge2", 32'(pedge0), 32'h01);
        ack = 8'h01;
        step();
        chk("set_vs_ack", 32'(pend0), 32'h01);
        step();
        ack = 8'h00;
        chk("ack_alone", 32'(pend0), 32'h0);
        chk("bit0_cnt", 32'(cnt0), 32'd5);

        // clr overrides a concurrent set and increment.
        din = 8'h7A;
        run(3);
        din = 8'h7B;
        run(3);
        chk("clr_pedge", 32'(pedge0), 32'h01);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_pend", 32'(pend0), 32'h0);
        chk("clr_cnt", 32'(cnt0), 32'h0);
        chk("clr_cnt1", 32'(cnt1), 32'h0);
        step();
        chk("clr_pend_hold", 32'(pend0), 32'h0);

        // Fresh start, then saturation of the 2-bit counter.
        rst_n = 1'b0;
        din   = 8'h00;
        step();
        rst_n = 1'b1;
        run(4);
        for (int k = 0; k < 5; k++) begin
            din = 8'h01;
            run(3);
            step();
            chk($sformatf("sat_cnt%0d", k), 32'(cnt1), 32'(sat_exp[k]));
            din = 8'h00;
            run(3);
        end
        chk("sat_cnt0", 32'(cnt0), 32'd5);
        chk("sat_irq", 32'(irq0), 32'h1);

        // Asynchronous reset mid-cycle clears everything at once.
        din = 8'hFF;
        step();
        #3;
        rst_n = 1'b0;
        #1;
        chk_zero("async_rst");
        chk("async_rst_pend1", 32'(pend1), 32'h0);
        chk("async_rst_irq1", 32'(irq1), 32'h0);
        step();
        rst_n = 1'b1;
        run(6);
        chk("rewarm_pedge", 32'(seen), 32'h0);
        chk("rewarm_pend", 32'(pend0), 32'h0);
        chk("rewarm_cnt", 32'(cnt0), 32'h0);

        // Detection resumes after the repeated warm-up.
        din = 8'h00;
        run(3);
        din = 8'h01;
        run(3);
        chk("post_rewarm", 32'(pedge0), 32'h01);
        chk("post_rewarm1", 32'(pedge1), 32'h01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sync_edge_detect.md
SYNC_EDGE_DETECT -- requirements
Module: sync_edge_detect

Interface
REQ-001 Parameter WIDTH, default 8: number of independent input channels; legal range 1..32.
REQ-002 Parameter SYNC_STAGES, default 2: synchroniser flops per channel; legal range 2..4.
REQ-003 Parameter CNT_W, default 8: event-counter width; legal range 2..16.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset; assertion acts immediately, release is synchronous to clk.
REQ-006 in  input  WIDTH  asynchronous level inputs, one per channel.
REQ-007 mode  input  2  detect mode, applied to all channels: 00 rising, 01 falling, 10 any change, 11 disabled.
REQ-008 clr  input  1  synchronous clear of pending and evt_cnt.
REQ-009 ack  input  WIDTH  per-channel acknowledge; a 1 clears that channel's pending bit.
REQ-010 pedge  output  WIDTH  registered one-cycle pulse per detected edge, per channel.
REQ-011 pending  output  WIDTH  sticky per-channel event flag.
REQ-012 irq  output  1  OR-reduction of pending, registered.
REQ-013 evt_cnt  output  CNT_W  saturating count of cycles in which any pedge bit was 1.

Function
REQ-014 Each channel SHALL pass through a SYNC_STAGES-deep flop chain; s denotes the last stage and p a register holding s delayed by one cycle.
REQ-015 Detect term per bit SHALL be: rising s&~p; falling ~s&p; any s^p; disabled 0; pedge SHALL register this term each cycle.
REQ-016 Latency: an in bit that changes and stays stable before capture edge E1 SHALL produce pedge high during exactly the cycle after edge E(SYNC_STAGES+1), for one cycle only.
REQ-017 A pulse on in shorter than one clk period SHALL carry no detection guarantee; a level held at least 2 cycles SHALL be detected exactly once per transition.
REQ-018 After reset release, detection SHALL be suppressed until a warm-up counter has seen SYNC_STAGES+1 rising edges; a static high input at reset release SHALL NOT generate pedge.
REQ-019 During warm-up, pedge, pending and evt_cnt SHALL remain 0, while the sync chain and p load normally.
REQ-020 mode changes SHALL take effect on the detect term evaluated in the same cycle; no retroactive detection of earlier edges.
REQ-021 pending[i] SHALL set on the cycle after pedge[i] is 1 and clear on the cycle after ack[i] is 1; simultaneous set and ack SHALL leave it set.
REQ-022 clr SHALL clear all pending bits and evt_cnt on the next edge, overriding any simultaneous set or increment.
REQ-023 evt_cnt SHALL increment by 1 (not by popcount) per cycle with any pedge bit high and saturate at 2^CNT_W-1 without wrapping.
REQ-024 irq SHALL equal the registered OR of pending, lagging pending by one cycle.
REQ-025 Channels SHALL be fully independent; edges on several channels in one cycle SHALL each assert their own pedge bit.

Reset
REQ-026 Asserting rst_n low SHALL immediately clear all sync flops, p, pedge, pending, irq, evt_cnt and the warm-up counter to 0, including mid-operation.
REQ-027 Reset asserted mid-warm-up or mid-pulse SHALL restart warm-up from zero on release.

Verification
REQ-028 WIDTH=8, SYNC_STAGES=2, mode=00: after warm-up, in 0x00->0x05 held -> pedge=0x05 for one cycle 3 edges after capture; pending=0x05; irq next cycle; evt_cnt=1.
REQ-029 mode=01 then 10: in 0x05->0x04 -> pedge=0x01 (falling); mode=10, in 0x04->0x84 -> pedge=0x80; mode=11 -> no pedge for any change.
REQ-030 in=0xFF held through reset release -> pedge, pending, evt_cnt remain 0 after warm-up.
REQ-031 pending=0x01, ack=0x01 in the same cycle as a new pedge[0] -> pending[0] stays 1; ack alone next cycle -> 0; clr with concurrent pedge -> pending=0, evt_cnt=0.
REQ-032 CNT_W=2: drive 5 separated edges -> evt_cnt 1,2,3,3,3; rst_n pulsed low mid-sequence -> all outputs 0 immediately and warm-up repeats.
